// File: rtl/zero_pattern_gen_pkg.sv
// Shared types and helpers for zero_pattern_gen: FSM state encoding, default
// width and the largest-N-zero-word function used by the optional out_last.
package zero_pattern_pkg;

  localparam int unsigned DATA_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD,
    DONE
  } state_e;

  // Largest data_w-bit word with exactly n zeros: ones high, zeros in the low n bits.
  function automatic logic [63:0] max_zero_word(input int unsigned data_w,
                                                input int unsigned n);
    logic [63:0] w;
    w = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if ((i >= n) && (i < data_w)) w[i] = 1'b1;
    end
    return w;
  endfunction

endpackage

// File: rtl/zero_pattern_gen_byte_zero_counter.sv
// Combinational count of zero bits in a DATA_W-bit vector.
module byte_zero_counter
  import zero_pattern_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  count
);

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      count = count + CNT_W'(~data[i]);
    end
  end

endmodule

// File: rtl/zero_pattern_gen.sv
// Emits every DATA_W-bit word with exactly `zeros` zero bits, ascending, on a
// valid/ready stream. Optional out_last port: define ZERO_PATTERN_GEN_LAST_EN.
module zero_pattern_gen
  import zero_pattern_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  zeros,
  output logic              busy,
  output logic              err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] out_count,
  output logic              done
`ifdef ZERO_PATTERN_GEN_LAST_EN
  , output logic            out_last
`endif
);

  localparam logic [CNT_W:0]  MAX_ZEROS = (CNT_W + 1)'(DATA_W);
  localparam logic [DATA_W:0] CAND_ONE  = (DATA_W + 1)'(1);
  localparam logic [DATA_W:0] CAND_TOP  = {1'b0, {DATA_W{1'b1}}};

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   req_q, req_d;
  logic [DATA_W:0]    cand_q, cand_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [DATA_W-1:0]  count_q, count_d;

  logic [CNT_W-1:0]   zc;
  logic               cand_top;
  logic               scan_hit;
  logic               hs;

  byte_zero_counter #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_zero_cnt (
    .data  (cand_q[DATA_W-1:0]),
    .count (zc)
  );

  assign cand_top = (cand_q == CAND_TOP);
  assign scan_hit = (state_q == SCAN) && (zc == req_q);
  assign hs       = (state_q == HOLD) && valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cand_d  = cand_q;
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if ({1'b0, zeros} > MAX_ZEROS) begin
            err_d = 1'b1;
          end else begin
            req_d   = zeros;
            cand_d  = '0;
            count_d = '0;
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (scan_hit) begin
          data_d  = cand_q[DATA_W-1:0];
          valid_d = 1'b1;
          state_d = HOLD;
        end else if (cand_top) begin
          state_d = DONE;
        end else begin
          cand_d = cand_q + CAND_ONE;
        end
      end
      HOLD: begin
        if (hs) begin
          valid_d = 1'b0;
          count_d = count_q + DATA_W'(1);
          if (cand_top) begin
            state_d = DONE;
          end else begin
            cand_d  = cand_q + CAND_ONE;
            state_d = SCAN;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Status flags follow the next state so they line up with it.
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      cand_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cand_q  <= cand_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign busy      = busy_q;
  assign err       = err_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_count = count_q;
  assign done      = done_q;

`ifdef ZERO_PATTERN_GEN_LAST_EN
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (scan_hit) begin
      last_d = (cand_q[DATA_W-1:0] == DATA_W'(max_zero_word(DATA_W, 32'(req_q))));
    end else if (hs) begin
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b0;
    else        last_q <= last_d;
  end

  assign out_last = last_q;
`else
  // Without out_last, run completion is visible only through done.
`endif

endmodule

// File: tb/tb_zero_pattern_gen.sv
// Self-checking bench for zero_pattern_gen: table-driven runs plus stall, error
// and mid-run reset sequences, with a pattern scoreboard.
module tb_zero_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] zeros;
  logic       busy;
  logic       err;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [7:0] out_count;
  logic       done;
`ifdef ZERO_PATTERN_GEN_LAST_EN
  logic       out_last;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [7:0]  sb[$];

  typedef struct {
    logic [3:0]  zeros;
    int unsigned exp_n;
    logic [7:0]  first;
    logic [7:0]  last;
    bit          rnd_ready;
  } vec_t;

  vec_t vecs[6];

  zero_pattern_gen #(
    .DATA_W (8),
    .CNT_W  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .zeros     (zeros),
    .busy      (busy),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .done      (done)
`ifdef ZERO_PATTERN_GEN_LAST_EN
    , .out_last (out_last)
`endif
  );

  always #5 clk = ~clk;

  function automatic int unsigned zcount(input logic [7:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 8; i++) if (!v[i]) c++;
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic start_run(input logic [3:0] z);
    @(negedge clk);
    zeros = z;
    start = 1'b1;
    sb.delete();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] b;
      b = 8'(v);
      if (zcount(b) == 32'(z)) sb.push_back(b);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Consume patterns; stop_after > 0 returns after that many handshakes.
  task automatic drain(input int unsigned exp_n, input logic [7:0] first,
                       input logic [7:0] last, input bit rnd,
                       input int unsigned stop_after);
    int unsigned got;
    bit          seen_done;
    logic [7:0]  exp;
    logic [7:0]  prev;
    got = 0;
    seen_done = 1'b0;
    prev = '0;
    for (int cyc = 0; cyc < 6000 && !seen_done; cyc++) begin
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          fail_now("extra_pattern");
          exp = '0;
        end else begin
          exp = sb.pop_front();
        end
        chk("out_data", 32'(out_data), 32'(exp));
        if (got == 0) chk("first_pattern", 32'(out_data), 32'(first));
`ifdef ZERO_PATTERN_GEN_LAST_EN
        chk("out_last", 32'(out_last), 32'(got + 1 == exp_n));
`endif
        prev = out_data;
        got++;
        if (stop_after != 0 && got == stop_after) return;
      end
      if (done) begin
        seen_done = 1'b1;
        chk("done_out_count", 32'(out_count), exp_n);
        chk("done_pattern_total", got, exp_n);
        chk("done_queue_empty", 32'(sb.size()), 32'd0);
        chk("last_pattern", 32'(prev), 32'(last));
      end
      @(negedge clk);
    end
    if (!seen_done) fail_now("drain_timeout");
    @(negedge clk);
    chk("idle_after_done", {busy, done}, 32'd0);
  endtask

  initial begin
    bit seen;

    vecs[0] = '{zeros: 4'd8, exp_n: 1,  first: 8'h00, last: 8'h00, rnd_ready: 1'b0};
    vecs[1] = '{zeros: 4'd7, exp_n: 8,  first: 8'h01, last: 8'h80, rnd_ready: 1'b0};
    vecs[2] = '{zeros: 4'd1, exp_n: 8,  first: 8'h7F, last: 8'hFE, rnd_ready: 1'b0};
    vecs[3] = '{zeros: 4'd4, exp_n: 70, first: 8'h0F, last: 8'hF0, rnd_ready: 1'b1};
    vecs[4] = '{zeros: 4'd2, exp_n: 28, first: 8'h3F, last: 8'hFC, rnd_ready: 1'b1};
    vecs[5] = '{zeros: 4'd6, exp_n: 28, first: 8'h03, last: 8'hC0, rnd_ready: 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    zeros = '0;
    out_ready = 1'b0;
    #12;
    chk("reset_state", {busy, err, out_valid, done, out_data, out_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      start_run(vecs[i].zeros);
      drain(vecs[i].exp_n, vecs[i].first, vecs[i].last, vecs[i].rnd_ready, 0);
    end

    // zeros=0 with downstream stalled for five cycles after out_valid.
    out_ready = 1'b0;
    start_run(4'd0);
    seen = 1'b0;
    for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
      if (out_valid) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) fail_now("stall_wait_valid");
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold", {out_valid, out_data}, {23'd0, 1'b1, 8'hFF});
      @(negedge clk);
    end
    drain(1, 8'hFF, 8'hFF, 1'b0, 0);

    // Out-of-range request.
    @(negedge clk);
    zeros = 4'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("err_pulse", {err, busy}, 32'd2);
    @(posedge clk);
    #1;
    chk("err_one_cycle", 32'(err), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    chk("err_no_activity", 32'(seen), 32'd0);

    // Asynchronous reset in the middle of a run, then a fresh run.
    start_run(4'd4);
    drain(70, 8'h0F, 8'hF0, 1'b0, 10);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_run", {busy, err, out_valid, done, out_data, out_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_run(4'd6);
    drain(28, 8'h03, 8'hC0, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
